// File: rtl/lc3_mem_pkg.sv
// lc3_mem_pkg: shared channel state type and LFSR constants for the LC3 memory responder
package lc3_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} chan_state_e;
  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
endpackage

// File: rtl/lc3_mem_chan.sv
// lc3_mem_chan: one request channel with wait-state counter and fixed/random latency select
module lc3_mem_chan
  import lc3_mem_pkg::*;
#(
  parameter int PAY_W = 16,
  parameter int LAT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic [PAY_W-1:0] i_pay,
  input  logic [LAT_W-1:0] i_cfg_lat,
  input  logic             i_rand_en,
  input  logic [LAT_W-1:0] i_rnd,
  output logic             o_fetch,
  output logic             o_done,
  output logic [PAY_W-1:0] o_pay
);
  chan_state_e      r_state, w_next;
  logic [LAT_W-1:0] r_cnt, w_lat;
  logic [PAY_W-1:0] r_pay;
  logic             w_acc;
  assign o_pay = r_pay;
  always_comb begin
    w_lat   = i_rand_en ? LAT_W'({1'b0, i_rnd} % ({1'b0, i_cfg_lat} + (LAT_W+1)'(1))) : i_cfg_lat;
    w_acc   = r_state == IDLE && i_req;
    o_fetch = r_state == WAIT && r_cnt == '0;
    o_done  = r_state == DONE;
    w_next  = w_acc ? WAIT : o_fetch ? DONE : o_done ? IDLE : r_state;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_pay   <= '0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_cnt <= w_lat;
        r_pay <= i_pay;
      end else if (r_state == WAIT && r_cnt != '0) r_cnt <= r_cnt - LAT_W'(1);
    end
  end
endmodule

// File: rtl/lc3_mem_responder.sv
// lc3_mem_responder: dual-channel LC3 memory model with programmable/random wait states and backdoor preload
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          DATA_W    = 16,
  parameter int          LAT_W     = 4,
  parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [LAT_W-1:0]  cfg_instr_lat,
  input  logic [LAT_W-1:0]  cfg_data_lat,
  input  logic              cfg_rand_en,
  input  logic [ADDR_W-1:0] pc,
  input  logic              instrmem_rd,
  output logic [DATA_W-1:0] Instr_dout,
  output logic              complete_instr,
  input  logic              data_req,
  input  logic [ADDR_W-1:0] Data_addr,
  input  logic [DATA_W-1:0] Data_din,
  input  logic              Data_rd,
  output logic [DATA_W-1:0] Data_dout,
  output logic              complete_data,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data
);
  localparam int DP_W = 1 + DATA_W + ADDR_W;
  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [15:0]       r_lfsr;
  logic [ADDR_W-1:0] w_i_addr, w_d_addr;
  logic [DATA_W-1:0] w_d_din;
  logic [DP_W-1:0]   w_d_pay;
  logic              w_d_rd, w_i_fetch, w_d_fetch;
  assign {w_d_rd, w_d_din, w_d_addr} = w_d_pay;
  lc3_mem_chan #(.PAY_W(ADDR_W), .LAT_W(LAT_W)) u_instr (
    .i_clk(clock), .i_rst_n(reset), .i_req(instrmem_rd), .i_pay(pc),
    .i_cfg_lat(cfg_instr_lat), .i_rand_en(cfg_rand_en), .i_rnd(r_lfsr[LAT_W-1:0]),
    .o_fetch(w_i_fetch), .o_done(complete_instr), .o_pay(w_i_addr)
  );
  lc3_mem_chan #(.PAY_W(DP_W), .LAT_W(LAT_W)) u_data (
    .i_clk(clock), .i_rst_n(reset), .i_req(data_req), .i_pay({Data_rd, Data_din, Data_addr}),
    .i_cfg_lat(cfg_data_lat), .i_rand_en(cfg_rand_en), .i_rnd(r_lfsr[LAT_W+7:8]),
    .o_fetch(w_d_fetch), .o_done(complete_data), .o_pay(w_d_pay)
  );
  // later assignment wins: a committing data write overrides a same-address backdoor load
  always_ff @(posedge clock) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
    if (complete_data && !w_d_rd) r_mem[w_d_addr] <= w_d_din;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lfsr     <= LFSR_SEED;
      Instr_dout <= '0;
      Data_dout  <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
      if (w_i_fetch) Instr_dout <= r_mem[w_i_addr];
      if (w_d_fetch && w_d_rd) Data_dout <= r_mem[w_d_addr];
    end
  end
endmodule
